fifo_push_arbiter: RTL and testbench

Round-robin push arbiter and occupancy controller for the shared shift-register FIFO (`DEPTH` entries, `DATA_W` wide). It shares the FIFO's single push port between `NREQ` producers over valid/ready handshakes, grants bursts of up to `BURST` beats per owner, and forwards the consumer's pop requests. It also keeps a conservative occupancy mirror, so the FIFO is never pushed while full and never popped while empty.

---
 rtl/fifo_push_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter for a shared FIFO: grants bursts of up to BURST beats per
// producer and keeps a conservative occupancy mirror so the FIFO is never overrun.
module fifo_push_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_W-1:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            gnt,
    input  logic                       pop_req,
    input  logic                       fifo_empty,
    output logic                       fifo_push,
    output logic [DATA_W-1:0]          fifo_push_data,
    output logic                       fifo_pop,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned BW = $clog2(BURST+1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StOwn  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push_q, push_d;
    logic [DATA_W-1:0] push_data_q, push_data_d;

    logic              full;
    logic              owner_valid;
    logic              accept;
    logic [DATA_W-1:0] owner_data;
    logic              win_found;
    logic [IW-1:0]     win_idx;
    int unsigned       cand;

    // While owning, last_q is the owner index.
    assign full        = (cnt_q == CW'(DEPTH));
    assign owner_valid = req_valid[last_q];
    assign accept      = (state_q == StOwn) && owner_valid && !full;
    assign req_ready   = gnt_q & {NREQ{~full}};
    assign fifo_pop    = pop_req & ~fifo_empty;

    assign gnt            = gnt_q;
    assign fifo_push      = push_q;
    assign fifo_push_data = push_data_q;
    assign level          = cnt_q;
    assign busy           = (state_q == StOwn);

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (last_q == IW'(i)) begin
                owner_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Search upward from last+1, wrapping, so the previous owner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (k + 32'(last_q)) % NREQ;
            if (!win_found && req_valid[IW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        bcnt_d      = bcnt_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d          = StOwn;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    last_d           = win_idx;
                    bcnt_d           = '0;
                end
            end
            StOwn: begin
                if (accept) begin
                    push_d      = 1'b1;
                    push_data_d = owner_data;
                    bcnt_d      = bcnt_q + 1'b1;
                end
                if (!owner_valid || (accept && bcnt_q == BW'(BURST-1))) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Mirror counts at accept time, one cycle ahead of the FIFO write.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !fifo_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && fifo_pop && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            last_q      <= IW'(NREQ-1);
            bcnt_q      <= '0;
            cnt_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            bcnt_q      <= bcnt_d;
            cnt_q       <= cnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model with an attached FIFO queue.
module tb_fifo_push_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int BURST  = 4;
    localparam int CW     = $clog2(DEPTH+1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        gnt;
    logic                   pop_req;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic [DATA_W-1:0]      fifo_push_data;
    logic                   fifo_pop;
    logic [CW-1:0]          level;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    // Model: owner (-1 = nobody), last winner, beats in this grant, occupancy, push register
    int                m_own;
    int                m_last;
    int                m_bcnt;
    int                m_cnt;
    logic              m_push;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] fq[$];

    fifo_push_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .BURST  (BURST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .gnt            (gnt),
        .pop_req        (pop_req),
        .fifo_empty     (fifo_empty),
        .fifo_push      (fifo_push),
        .fifo_push_data (fifo_push_data),
        .fifo_pop       (fifo_pop),
        .level          (level),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NREQ-1:0] exp_gnt();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_own >= 0) g[m_own] = 1'b1;
        return g;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        return (m_cnt < DEPTH) ? exp_gnt() : '0;
    endfunction

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_last = NREQ - 1;
        m_bcnt = 0;
        m_cnt  = 0;
        m_push = 1'b0;
        m_data = '0;
        fq.delete();
        fifo_empty = 1'b1;
    endtask

    // Advance one clock: model consumes current inputs, DUT sees the same edge.
    task automatic tick();
        int                acc;
        int                pop;
        int                n_own;
        int                n_last;
        int                n_bcnt;
        int                n_cnt;
        logic              n_push;
        logic [DATA_W-1:0] n_data;
        pop = (pop_req && fq.size() != 0) ? 1 : 0;
        acc = (m_own >= 0 && req_valid[m_own] && m_cnt < DEPTH) ? 1 : 0;
        n_push = (acc != 0);
        n_data = (acc != 0) ? req_data[m_own*DATA_W +: DATA_W] : m_data;
        n_cnt  = m_cnt + acc - pop;
        if (n_cnt < 0) n_cnt = 0;
        if (n_cnt > DEPTH) n_cnt = DEPTH;
        n_own  = m_own;
        n_last = m_last;
        n_bcnt = m_bcnt;
        if (m_own < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_last + k) % NREQ;
                if (n_own < 0 && req_valid[j]) begin
                    n_own  = j;
                    n_last = j;
                    n_bcnt = 0;
                end
            end
        end else if (!req_valid[m_own]) begin
            n_own = -1;
        end else if (acc != 0) begin
            n_bcnt = m_bcnt + 1;
            if (n_bcnt == BURST) n_own = -1;
        end
        if (pop != 0) void'(fq.pop_front());
        if (m_push) fq.push_back(m_data);
        @(posedge clk);
        #1;
        m_own  = n_own;
        m_last = n_last;
        m_bcnt = n_bcnt;
        m_cnt  = n_cnt;
        m_push = n_push;
        m_data = n_data;
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        pop_req   = 1'b0;
        fifo_empty = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_data = '1; pop_req = 1'b1; fifo_empty = 1'b0;
        @(posedge clk); #1;
        checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b want=0", gnt); end
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b want=0", req_ready); end
        checks++; if (fifo_push !== 1'b0 || fifo_push_data !== '0) begin failures++;
            $display("FAIL reset_push got=%b/%h want=0/0", fifo_push, fifo_push_data); end
        checks++; if (level !== '0 || busy !== 1'b0) begin failures++;
            $display("FAIL reset_level_busy got=%0d/%b want=0/0", level, busy); end
        checks++; if (fifo_pop !== 1'b1) begin failures++; $display("FAIL pop_pass got=%b want=1", fifo_pop); end
        fifo_empty = 1'b1; #1;
        checks++; if (fifo_pop !== 1'b0) begin failures++; $display("FAIL pop_gate got=%b want=0", fifo_pop); end
        do_reset();
        tick();
        checks++; if (gnt !== '0 || busy !== 1'b0) begin failures++;
            $display("FAIL idle_no_req got=%b/%b want=0/0", gnt, busy); end
    endtask

    task automatic test_single_burst();
        int                beats;
        logic              rdy;
        logic [DATA_W-1:0] pd[$];
        int                pc[$];
        int                exp_cyc[6];
        exp_cyc = '{2, 3, 4, 5, 7, 8};
        do_reset();
        beats = 0;
        for (int c = 0; c < 16; c++) begin
            req_valid = (beats < 6) ? 4'b0100 : 4'b0000;
            set_data(2, 32'hA0 + beats);
            #1;
            rdy = req_ready[2];
            if (c == 1) begin
                checks++; if (gnt !== 4'b0100) begin failures++;
                    $display("FAIL burst_first_gnt got=%b want=0100", gnt); end
            end
            tick();
            if (rdy && req_valid[2]) beats++;
            if (fifo_push) begin pd.push_back(fifo_push_data); pc.push_back(c + 1); end
        end
        checks++; if (pd.size() != 6) begin failures++;
            $display("FAIL burst_push_count got=%0d want=6", pd.size()); end
        for (int i = 0; i < 6 && i < pd.size(); i++) begin
            checks++; if (pd[i] !== 32'hA0 + i || pc[i] != exp_cyc[i]) begin failures++;
                $display("FAIL burst_beat%0d got=%h@%0d want=%h@%0d", i, pd[i], pc[i], 32'hA0 + i, exp_cyc[i]); end
        end
        checks++; if (level !== CW'(6) || gnt !== '0) begin failures++;
            $display("FAIL burst_end got=%0d/%b want=6/0", level, gnt); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] prev;
        logic [NREQ-1:0] seq[$];
        logic [NREQ-1:0] want[5];
        int              no_bubble;
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_data(i, 32'h100 * i);
        pop_req   = 1'b1;
        prev      = '0;
        no_bubble = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gnt !== prev) begin
                if (gnt !== '0) seq.push_back(gnt);
                if (gnt !== '0 && prev !== '0) no_bubble++;
                prev = gnt;
            end
        end
        checks++; if (seq.size() < 5) begin failures++;
            $display("FAIL rr_grant_count got=%0d want>=5", seq.size()); end
        for (int i = 0; i < 5 && i < seq.size(); i++) begin
            checks++; if (seq[i] !== want[i]) begin failures++;
                $display("FAIL rr_order%0d got=%b want=%b", i, seq[i], want[i]); end
        end
        checks++; if (no_bubble != 0) begin failures++;
            $display("FAIL rr_bubble got=%0d want=0", no_bubble); end
        pop_req = 1'b0;
    endtask

    task automatic test_full_backpressure();
        int   sent;
        int   npush;
        logic rdy;
        do_reset();
        sent = 0; npush = 0;
        for (int c = 0; c < 24; c++) begin
            req_valid = (sent < 10) ? 4'b0001 : 4'b0000;
            set_data(0, 32'hB0 + sent);
            #1; rdy = req_ready[0];
            tick();
            if (rdy && req_valid[0]) sent++;
            if (fifo_push) npush++;
        end
        checks++; if (npush != DEPTH || level !== CW'(DEPTH)) begin failures++;
            $display("FAIL full_fill got=%0d/%0d want=8/8", npush, level); end
        checks++; if (req_ready !== '0 || busy !== 1'b1 || gnt !== 4'b0001) begin failures++;
            $display("FAIL full_stall got=%b/%b/%b want=0000/1/0001", req_ready, busy, gnt); end
        pop_req = 1'b1;
        tick();
        if (fifo_push) npush++;
        pop_req = 1'b0;
        checks++; if (level !== CW'(DEPTH-1) || req_ready !== 4'b0001) begin failures++;
            $display("FAIL full_pop got=%0d/%b want=7/0001", level, req_ready); end
        for (int c = 0; c < 4; c++) begin
            req_valid = (sent < 10) ? 4'b0001 : 4'b0000;
            set_data(0, 32'hB0 + sent);
            #1; rdy = req_ready[0];
            tick();
            if (rdy && req_valid[0]) sent++;
            if (fifo_push) npush++;
        end
        checks++; if (npush != DEPTH + 1 || level !== CW'(DEPTH) || req_ready !== '0) begin failures++;
            $display("FAIL full_one_more got=%0d/%0d/%b want=9/8/0000", npush, level, req_ready); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 4'b0001;
        set_data(0, 32'hC0);
        for (int c = 0; c < 20; c++) tick();
        pop_req = 1'b1;
        tick();
        checks++; if (level !== CW'(DEPTH-1)) begin failures++;
            $display("FAIL sim_pre got=%0d want=7", level); end
        tick();
        checks++; if (level !== CW'(DEPTH-1) || req_ready !== 4'b0001 || fifo_push !== 1'b1) begin
            failures++;
            $display("FAIL sim_acc_pop got=%0d/%b/%b want=7/0001/1", level, req_ready, fifo_push); end
        pop_req = 1'b0;
    endtask

    task automatic test_owner_drop();
        int   beats;
        logic rdy;
        logic [NREQ-1:0] want[3];
        want = '{4'b0010, 4'b0010, 4'b0000};
        do_reset();
        beats = 0;
        req_valid = 4'b0010;
        set_data(1, 32'hD1); set_data(0, 32'hD0); set_data(3, 32'hD3);
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++;
            $display("FAIL drop_gnt1 got=%b want=0010", gnt); end
        for (int c = 1; c <= 3; c++) begin
            req_valid = {1'b1, 1'b0, (beats < 2), 1'b1};
            #1; rdy = req_ready[1];
            tick();
            if (rdy && req_valid[1]) beats++;
            checks++; if (gnt !== want[c-1]) begin failures++;
                $display("FAIL drop_cycle%0d got=%b want=%b", c + 1, gnt, want[c-1]); end
        end
        checks++; if (beats != 2) begin failures++; $display("FAIL drop_beats got=%0d want=2", beats); end
        tick();
        checks++; if (gnt !== 4'b1000) begin failures++;
            $display("FAIL drop_next_owner got=%b want=1000", gnt); end
    endtask

    task automatic test_reset_mid_burst();
        int found;
        do_reset();
        req_valid = 4'b0001;
        set_data(0, 32'hE0);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (fifo_push === 1'b1 && level === CW'(5)) found = 1;
        end
        checks++; if (found != 1) begin failures++; $display("FAIL rmb_reach got=%0d want=1", found); end
        #1 rst = 1'b1;
        #1;
        checks++; if (fifo_push !== 1'b0 || gnt !== '0 || level !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rmb_async got=%b/%b/%0d/%b want=0/0/0/0", fifo_push, gnt, level, busy); end
        #2 rst = 1'b0;
        model_reset();
        req_valid = '1;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++;
            $display("FAIL rmb_priority got=%b want=0001", gnt); end
    endtask

    task automatic test_random();
        int pop_pct;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            pop_pct = (c % 600 < 300) ? 25 : 80;
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                set_data(i, $urandom);
            end
            pop_req = ($urandom_range(0, 99) < pop_pct);
            #1;
            checks++; if (gnt !== exp_gnt() || busy !== (m_own >= 0)) begin failures++;
                $display("FAIL rnd_gnt c=%0d got=%b/%b want=%b", c, gnt, busy, exp_gnt()); end
            checks++; if (req_ready !== exp_ready()) begin failures++;
                $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, exp_ready()); end
            checks++; if (level !== CW'(m_cnt) || int'(level) < fq.size()) begin failures++;
                $display("FAIL rnd_level c=%0d got=%0d want=%0d fifo=%0d", c, level, m_cnt, fq.size()); end
            checks++; if (fifo_push !== m_push || fifo_push_data !== m_data) begin failures++;
                $display("FAIL rnd_push c=%0d got=%b/%h want=%b/%h", c, fifo_push, fifo_push_data,
                         m_push, m_data); end
            checks++; if (fifo_pop !== (pop_req && fq.size() != 0)) begin failures++;
                $display("FAIL rnd_pop c=%0d got=%b", c, fifo_pop); end
            tick();
        end
        pop_req = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_backpressure();
        test_simultaneous();
        test_owner_drop();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
